// File: rtl/pipe_pkg.sv
// Shared pipeline types: PC source encodings, register zero, and the per-stage shadow record.
package pipe_pkg;

    localparam int PIPE_REG_AW = 5;

    localparam logic [1:0] PCSRC_INC    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [PIPE_REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [PIPE_REG_AW-1:0] dest;
        logic                   regWrite;
        logic                   memRead;
    } shadow_t;

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage decode inputs and PC/IF-ID control outputs of the hazard controller.
// The slave side is the hazard unit; the master side is the datapath driving it.
interface hazard_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] idRs;
    logic [REG_AW-1:0] idRt;
    logic              idUsesRs;
    logic              idUsesRt;
    logic [REG_AW-1:0] idDest;
    logic              idRegWrite;
    logic              idMemRead;
    logic              idBranch;
    logic              idJump;
    logic              branchTaken;

    logic [1:0]        pcSrc;
    logic              pcWrite;
    logic              ifFlush;
    logic              ifidWrite;
    logic              stall;

    modport slave (
        input  idRs, idRt, idUsesRs, idUsesRt, idDest, idRegWrite, idMemRead,
               idBranch, idJump, branchTaken,
        output pcSrc, pcWrite, ifFlush, ifidWrite, stall
    );

    modport master (
        output idRs, idRt, idUsesRs, idUsesRt, idDest, idRegWrite, idMemRead,
               idBranch, idJump, branchTaken,
        input  pcSrc, pcWrite, ifFlush, ifidWrite, stall
    );
endinterface

// File: rtl/hazard_match.sv
// Source-vs-stage register compare: flags a read of a live, non-r0 destination in one stage.
// Latency: purely combinational.  Backpressure: none.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic              useSrc,
    input  logic [REG_AW-1:0] src,
    input  shadow_t           stage,
    output logic              match,
    output logic              matchLoad
);
    assign match     = useSrc && stage.regWrite && (stage.dest != REG_ZERO) && (src == stage.dest);
    assign matchLoad = match && stage.memRead;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use / branch-in-ID stalls and fetch redirect; optional counters under HAZARD_STATS_EN.
// Latency: outputs combinational from ID inputs and shadow state; shadows update on each rising clk.
// Backpressure: holds PC and IF/ID and bubbles ID/EX while a hazard is present.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = PIPE_REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   stallCount,
    output logic [31:0]   flushCount
`endif
);

    shadow_t exSh;
    shadow_t memSh;

    logic rsEx, rtEx, rsMem, rtMem;
    logic rsExLd, rtExLd, rsMemLd, rtMemLd;

    hazard_match #(.REG_AW(REG_AW)) uRsEx (
        .useSrc(hz.idUsesRs), .src(hz.idRs), .stage(exSh),  .match(rsEx),  .matchLoad(rsExLd)
    );
    hazard_match #(.REG_AW(REG_AW)) uRtEx (
        .useSrc(hz.idUsesRt), .src(hz.idRt), .stage(exSh),  .match(rtEx),  .matchLoad(rtExLd)
    );
    hazard_match #(.REG_AW(REG_AW)) uRsMem (
        .useSrc(hz.idUsesRs), .src(hz.idRs), .stage(memSh), .match(rsMem), .matchLoad(rsMemLd)
    );
    hazard_match #(.REG_AW(REG_AW)) uRtMem (
        .useSrc(hz.idUsesRt), .src(hz.idRt), .stage(memSh), .match(rtMem), .matchLoad(rtMemLd)
    );

    logic exHit, exLoadHit, memLoadHit;
    logic loadUse, branchAlu, branchLoad, hazard;

    assign exHit      = rsEx | rtEx;
    assign exLoadHit  = rsExLd | rtExLd;
    assign memLoadHit = rsMemLd | rtMemLd;

    // A branch reading an ALU result in MEM needs no stall: it is forwarded into the ID comparator.
    assign loadUse    = exLoadHit;
    assign branchAlu  = hz.idBranch && exHit && !exSh.memRead;
    assign branchLoad = hz.idBranch && (exLoadHit || memLoadHit);
    assign hazard     = loadUse || branchAlu || branchLoad;

    logic [1:0] pcSrcC;
    logic       pcWriteC, ifFlushC, ifidWriteC, stallC;

    always_comb begin
        pcSrcC     = PCSRC_INC;
        pcWriteC   = 1'b0;
        ifFlushC   = 1'b0;
        ifidWriteC = 1'b0;
        stallC     = 1'b0;
        if (!rst) begin
            if (hazard) begin
                stallC = 1'b1;
            end else begin
                pcWriteC   = 1'b1;
                ifidWriteC = 1'b1;
                if (hz.idJump) begin
                    pcSrcC   = PCSRC_JUMP;
                    ifFlushC = 1'b1;
                end else if (hz.idBranch && hz.branchTaken) begin
                    pcSrcC   = PCSRC_BRANCH;
                    ifFlushC = 1'b1;
                end
            end
        end
    end

    assign hz.pcSrc     = pcSrcC;
    assign hz.pcWrite   = pcWriteC;
    assign hz.ifFlush   = ifFlushC;
    assign hz.ifidWrite = ifidWriteC;
    assign hz.stall     = stallC;

    // Multi-cycle stalls fall out of bubbles walking from EX into MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exSh  <= '0;
            memSh <= '0;
        end else begin
            memSh <= exSh;
            if (stallC) begin
                exSh <= '0;
            end else begin
                exSh <= '{dest: hz.idDest, regWrite: hz.idRegWrite, memRead: hz.idMemRead};
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stallC) begin
                stallCount <= stallCount + 32'd1;
            end
            if (ifFlushC) begin
                flushCount <= flushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboarded random + directed bench for hazard_unit; stats checks only when HAZARD_STATS_EN is defined.
module tb_hazard_unit;

    typedef struct {
        logic [4:0] rs, rt, dest;
        logic usesRs, usesRt, regWrite, memRead, branch, jump;
    } instr_t;

    typedef struct packed {
        logic [1:0] pcSrc;
        logic pcWrite, ifFlush, ifidWrite, stall;
    } exp_t;

    logic clk;
    logic rst;

    hazard_unit_if #(.REG_AW(5)) hif();

`ifdef HAZARD_STATS_EN
    logic [31:0] stallCount, flushCount;
    hazard_unit #(.REG_AW(5)) dut (.clk(clk), .rst(rst), .hz(hif),
                                   .stallCount(stallCount), .flushCount(flushCount));
`else
    hazard_unit #(.REG_AW(5)) dut (.clk(clk), .rst(rst), .hz(hif));
`endif

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    exp_t expQ[$];
    int   cmpCnt = 0;
    int   errCnt = 0;
    int   cycle  = 0;

    // Reference model: the two most recent instructions that left ID, youngest first.
    logic [4:0] pDest[2];
    bit         pWr[2];
    bit         pLd[2];
    int unsigned sCnt = 0;
    int unsigned fCnt = 0;

    function automatic instr_t mk(input int rs, input int rt, input bit ur, input bit ut,
                                  input int dest, input bit wr, input bit ld,
                                  input bit br, input bit jp);
        instr_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.usesRs = ur; i.usesRt = ut;
        i.dest = 5'(dest); i.regWrite = wr; i.memRead = ld; i.branch = br; i.jump = jp;
        return i;
    endfunction

    function automatic bit readsAt(input instr_t i, input int a);
        if (!pWr[a] || pDest[a] == 0) return 0;
        return (i.usesRs && i.rs == pDest[a]) || (i.usesRt && i.rt == pDest[a]);
    endfunction

    task automatic step(input instr_t i, input bit taken, input bit r,
                        output bit stalled, output bit flushed);
        exp_t e;
        bit   hzd;
        rst = r;
        hif.idRs = i.rs; hif.idRt = i.rt; hif.idUsesRs = i.usesRs; hif.idUsesRt = i.usesRt;
        hif.idDest = i.dest; hif.idRegWrite = i.regWrite; hif.idMemRead = i.memRead;
        hif.idBranch = i.branch; hif.idJump = i.jump; hif.branchTaken = taken;
        e = '0;
        if (r) begin
            for (int k = 0; k < 2; k++) begin pDest[k] = 0; pWr[k] = 0; pLd[k] = 0; end
            sCnt = 0; fCnt = 0;
        end else begin
            hzd = (readsAt(i, 0) && (pLd[0] || i.branch)) || (i.branch && readsAt(i, 1) && pLd[1]);
            if (hzd) begin
                e.stall = 1;
            end else begin
                e.pcWrite = 1; e.ifidWrite = 1;
                if (i.jump)                begin e.pcSrc = 2; e.ifFlush = 1; end
                else if (i.branch && taken) begin e.pcSrc = 1; e.ifFlush = 1; end
            end
            pDest[1] = pDest[0]; pWr[1] = pWr[0]; pLd[1] = pLd[0];
            pDest[0] = hzd ? 5'd0 : i.dest;
            pWr[0]   = hzd ? 1'b0 : i.regWrite;
            pLd[0]   = hzd ? 1'b0 : i.memRead;
            if (e.stall)   sCnt++;
            if (e.ifFlush) fCnt++;
        end
        expQ.push_back(e);
        stalled = e.stall;
        flushed = e.ifFlush;
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction to ID and holds it there until the model says it has left.
    task automatic issue(input instr_t i, input bit taken, output bit flushed);
        bit s;
        flushed = 0;
        for (int k = 0; k < 4; k++) begin
            step(i, taken, 1'b0, s, flushed);
            if (!s) break;
        end
    endtask

    function automatic instr_t randInstr();
        int rs = $urandom_range(0, 3);
        int rt = $urandom_range(0, 3);
        int d  = $urandom_range(0, 3);
        case ($urandom_range(0, 5))
            0: return mk(rs, rt, 1, 1, d, 1, 0, 0, 0);
            1: return mk(rs, rt, 1, 0, d, 1, 1, 0, 0);
            2: return mk(rs, rt, 1, 1, 0, 0, 0, 1, 0);
            3: return mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
            4: return mk(rs, rt, 1, 1, 0, 0, 0, 0, 0);
            default: return mk(rs, rt, 1, 1, 0, 0, 0, 1, 1);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e, got;
        cycle++;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            got = {hif.pcSrc, hif.pcWrite, hif.ifFlush, hif.ifidWrite, hif.stall};
            cmpCnt++;
            if (got !== e) begin
                errCnt++;
                $display("FAIL outputs cycle %0d: got pcSrc=%0d pcWrite=%0b ifFlush=%0b ifidWrite=%0b stall=%0b, required pcSrc=%0d pcWrite=%0b ifFlush=%0b ifidWrite=%0b stall=%0b",
                         cycle, got.pcSrc, got.pcWrite, got.ifFlush, got.ifidWrite, got.stall,
                         e.pcSrc, e.pcWrite, e.ifFlush, e.ifidWrite, e.stall);
            end
        end
    end

`ifdef HAZARD_STATS_EN
    task automatic checkStats(input string tag);
        cmpCnt++;
        if (stallCount !== sCnt) begin
            errCnt++;
            $display("FAIL stallCount %s: got %0d required %0d", tag, stallCount, sCnt);
        end
        cmpCnt++;
        if (flushCount !== fCnt) begin
            errCnt++;
            $display("FAIL flushCount %s: got %0d required %0d", tag, flushCount, fCnt);
        end
    endtask
`endif

    initial begin
        instr_t nop, i;
        bit s, f;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        #1;
        step(nop, 1'b0, 1'b1, s, f);
        step(nop, 1'b1, 1'b1, s, f);
        step(nop, 1'b0, 1'b0, s, f);

        // Load-use, branch after ALU, branch after load, r0 immunity, jump.
        issue(mk(1, 0, 1, 0, 2, 1, 1, 0, 0), 1'b0, f);
        issue(mk(2, 4, 1, 1, 3, 1, 0, 0, 0), 1'b0, f);
        issue(nop, 1'b0, f);
        issue(nop, 1'b0, f);
        issue(mk(1, 1, 1, 1, 5, 1, 0, 0, 0), 1'b0, f);
        issue(mk(5, 0, 1, 1, 0, 0, 0, 1, 0), 1'b1, f);
        issue(nop, 1'b0, f);
        issue(mk(1, 0, 1, 0, 6, 1, 1, 0, 0), 1'b0, f);
        issue(mk(6, 7, 1, 1, 0, 0, 0, 1, 0), 1'b0, f);
        issue(mk(1, 0, 1, 0, 0, 1, 1, 0, 0), 1'b0, f);
        issue(mk(0, 0, 1, 1, 1, 1, 0, 0, 0), 1'b0, f);
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, f);
        issue(nop, 1'b0, f);
`ifdef HAZARD_STATS_EN
        checkStats("directed");
`endif

        // Reset during the first cycle of a two-cycle branch stall.
        issue(mk(1, 0, 1, 0, 6, 1, 1, 0, 0), 1'b0, f);
        i = mk(6, 7, 1, 1, 0, 0, 0, 1, 0);
        step(i, 1'b1, 1'b0, s, f);
        step(i, 1'b1, 1'b1, s, f);
        issue(i, 1'b1, f);
        issue(nop, 1'b0, f);

        f = 0;
        for (int n = 0; n < 300; n++) begin
            i = f ? nop : randInstr();
            issue(i, 1'($urandom_range(0, 1)), f);
        end
`ifdef HAZARD_STATS_EN
        checkStats("random");
        force dut.stallCount = 32'hFFFF_FFFF;
        #1;
        release dut.stallCount;
        issue(nop, 1'b0, f);
        issue(mk(1, 0, 1, 0, 2, 1, 1, 0, 0), 1'b0, f);
        issue(mk(2, 4, 1, 1, 3, 1, 0, 0, 0), 1'b0, f);
        cmpCnt++;
        if (stallCount !== 32'd0) begin
            errCnt++;
            $display("FAIL stallCount wrap: got %0d required 0", stallCount);
        end
`endif

        repeat (2) @(negedge clk);
        #1;
        cmpCnt++;
        if (expQ.size() != 0) begin
            errCnt++;
            $display("FAIL scoreboard drain: got %0d pending required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
